vp_recovery_ctrl: RTL

VP_RECOVERY_CTRL -- requirements
Module: vp_recovery_ctrl

---
 rtl/mips_core_pkg.sv | 17 +
 rtl/sat_counter.sv | 24 ++
 rtl/vp_recovery_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/mips_core_pkg.sv
// Shared core definitions: datapath widths, recovery FSM states and the
// default response timeout used by the value-prediction recovery controller.
package mips_core_pkg;

    localparam int unsigned DATA_WIDTH      = 32;
    localparam int unsigned ADDR_WIDTH      = 32;
    localparam int unsigned TIMEOUT_DEFAULT = 255;

    typedef enum logic [2:0] {
        StIdle,
        StPredict,
        StWaitResp,
        StRecover,
        StDone
    } vp_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for prediction statistics; holds at all-ones instead
// of wrapping.
module sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/vp_recovery_ctrl.sv
// Value-prediction recovery controller: requests a prediction on a D-cache
// miss, checks it against the real response and squashes/redirects on error.
module vp_recovery_ctrl
    import mips_core_pkg::*;
#(
    parameter int unsigned RECOVER_CYCLES = 3,
    parameter int unsigned TIMEOUT        = TIMEOUT_DEFAULT,
    parameter int unsigned CNT_WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_miss,
    input  logic [ADDR_WIDTH-1:0] load_pc,
    input  logic                  pred_valid,
    input  logic [DATA_WIDTH-1:0] pred_data,
    input  logic                  resp_valid,
    input  logic [DATA_WIDTH-1:0] resp_data,
    output logic                  vp_en,
    output logic                  recover_en,
    output logic                  flush,
    output logic                  redirect_valid,
    output logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  fix_valid,
    output logic [DATA_WIDTH-1:0] fix_data,
    output logic                  recovery_done,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  n_correct,
    output logic [CNT_WIDTH-1:0]  n_wrong
);

    localparam logic [7:0] WaitLast = 8'(TIMEOUT - 1);
    localparam logic [7:0] RecLast  = 8'(RECOVER_CYCLES - 1);

    vp_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] pred_q, pred_d;
    logic [DATA_WIDTH-1:0] resp_q, resp_d;
    logic                  timeout_q, timeout_d;
    logic [7:0]            wait_cnt_q, wait_cnt_d;
    logic [7:0]            rec_cnt_q, rec_cnt_d;
    logic                  inc_correct, inc_wrong;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            pc_q       <= '0;
            pred_q     <= '0;
            resp_q     <= '0;
            timeout_q  <= 1'b0;
            wait_cnt_q <= '0;
            rec_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pred_q     <= pred_d;
            resp_q     <= resp_d;
            timeout_q  <= timeout_d;
            wait_cnt_q <= wait_cnt_d;
            rec_cnt_q  <= rec_cnt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        pred_d         = pred_q;
        resp_d         = resp_q;
        timeout_d      = timeout_q;
        wait_cnt_d     = wait_cnt_q;
        rec_cnt_d      = rec_cnt_q;
        inc_correct    = 1'b0;
        inc_wrong      = 1'b0;
        vp_en          = 1'b0;
        recover_en     = 1'b0;
        flush          = 1'b0;
        redirect_valid = 1'b0;
        fix_valid      = 1'b0;
        recovery_done  = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Prediction request must be visible in the miss cycle itself.
                vp_en = load_miss & rst_n;
                if (load_miss) begin
                    pc_d    = load_pc;
                    state_d = StPredict;
                end
            end
            StPredict: begin
                vp_en = 1'b1;
                // Real data already here: the prediction is moot.
                if (resp_valid) begin
                    state_d = StDone;
                end else if (pred_valid) begin
                    pred_d     = pred_data;
                    wait_cnt_d = '0;
                    state_d    = StWaitResp;
                end
            end
            StWaitResp: begin
                recover_en = 1'b1;
                wait_cnt_d = wait_cnt_q + 8'd1;
                if (resp_valid) begin
                    if (resp_data == pred_q) begin
                        inc_correct = 1'b1;
                        state_d     = StDone;
                    end else begin
                        inc_wrong = 1'b1;
                        resp_d    = resp_data;
                        timeout_d = 1'b0;
                        rec_cnt_d = '0;
                        state_d   = StRecover;
                    end
                end else if (wait_cnt_q == WaitLast) begin
                    inc_wrong = 1'b1;
                    timeout_d = 1'b1;
                    rec_cnt_d = '0;
                    state_d   = StRecover;
                end
            end
            StRecover: begin
                flush          = 1'b1;
                redirect_valid = (rec_cnt_q == 8'd0);
                // No trustworthy value exists after a timeout.
                fix_valid      = redirect_valid & ~timeout_q;
                rec_cnt_d      = rec_cnt_q + 8'd1;
                if (rec_cnt_q == RecLast) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                recovery_done = 1'b1;
                state_d       = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign busy        = (state_q != StIdle);
    assign redirect_pc = redirect_valid ? (pc_q + ADDR_WIDTH'(4)) : '0;
    assign fix_data    = fix_valid ? resp_q : '0;

    sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_cnt_correct (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (inc_correct),
        .count (n_correct)
    );

    sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_cnt_wrong (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (inc_wrong),
        .count (n_wrong)
    );

endmodule
